// File: rtl/csa_tree_pipe.sv
// Pipelined 3:2 carry-save reduction of N_OPS W-bit operands to a sum/carry pair.
// Register stages every LAYERS_PER_STAGE layers, moved by one global advance signal.
module csa_tree_pipe #(
    parameter int unsigned N_OPS            = 92,
    parameter int unsigned W                = 184,
    parameter int unsigned LAYERS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_OPS*W-1:0] in_ops,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [W-1:0]     out_carry,
    output logic             busy
);

    // Row count after one 3:2 layer.
    function automatic int unsigned rows_next(input int unsigned r);
        return 2 * (r / 3) + (r % 3);
    endfunction

    function automatic int unsigned rows_after(input int unsigned n, input int unsigned k);
        int unsigned r;
        r = n;
        for (int unsigned j = 0; j < k; j++) r = rows_next(r);
        return r;
    endfunction

    function automatic int unsigned num_layers(input int unsigned n);
        int unsigned r;
        int unsigned c;
        r = n;
        c = 0;
        while (r > 2) begin
            r = rows_next(r);
            c++;
        end
        return c;
    endfunction

    localparam int unsigned NL    = num_layers(N_OPS);
    localparam int unsigned LPS   = LAYERS_PER_STAGE;
    localparam int unsigned DEPTH = (LPS == 0) ? 1 : (NL + LPS - 1) / LPS;

    if (N_OPS < 3) begin : g_chk_nops
        $error("csa_tree_pipe: N_OPS must be at least 3");
    end
    if (LPS == 0 || LPS > NL) begin : g_chk_lps
        $error("csa_tree_pipe: LAYERS_PER_STAGE must be in 1..NL");
    end

    logic             adv_c;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] v_q;

    // A full output stage that is not being consumed freezes the whole pipe.
    assign adv_c = !(v_q[DEPTH-1] && !out_ready);

    for (genvar l = 0; l < NL; l++) begin : g_layer
        localparam int unsigned RIN  = rows_after(N_OPS, l);
        localparam int unsigned ROUT = rows_next(RIN);
        localparam int unsigned NT   = RIN / 3;
        localparam int unsigned NR   = RIN % 3;

        logic [RIN*W-1:0]  lin;
        logic [ROUT*W-1:0] lout;

        if (l == 0) begin : g_src_in
            assign lin = in_ops;
        end else if (l % LPS == 0) begin : g_src_reg
            assign lin = g_stage[l/LPS-1].data_q;
        end else begin : g_src_comb
            assign lin = g_layer[l-1].lout;
        end

        // Carry shifted left by one; the bit out of the MSB is dropped.
        for (genvar t = 0; t < NT; t++) begin : g_csa
            assign lout[2*t*W +: W] = lin[3*t*W +: W] ^ lin[(3*t+1)*W +: W]
                                    ^ lin[(3*t+2)*W +: W];
            assign lout[(2*t+1)*W +: W] =
                ((lin[3*t*W +: W] & lin[(3*t+1)*W +: W])
               | (lin[3*t*W +: W] & lin[(3*t+2)*W +: W])
               | (lin[(3*t+1)*W +: W] & lin[(3*t+2)*W +: W])) << 1;
        end

        if (NR != 0) begin : g_pass
            assign lout[2*NT*W +: NR*W] = lin[3*NT*W +: NR*W];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        localparam int unsigned LAST = ((i + 1) * LPS < NL) ? (i + 1) * LPS : NL;
        localparam int unsigned R    = rows_after(N_OPS, LAST);

        logic [R*W-1:0] data_d;
        logic [R*W-1:0] data_q;

        always_comb begin
            data_d = data_q;
            if (adv_c) data_d = g_layer[LAST-1].lout;
        end

        // Only the output stage needs a data reset so out_sum/out_carry read zero.
        if (i == DEPTH - 1) begin : g_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) data_q <= '0;
                else        data_q <= data_d;
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                data_q <= data_d;
            end
        end
    end

    always_comb begin
        v_d = v_q;
        if (adv_c) begin
            v_d[0] = in_valid;
            for (int unsigned i = 1; i < DEPTH; i++) v_d[i] = v_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_q <= '0;
        else        v_q <= v_d;
    end

    assign in_ready  = adv_c;
    assign out_valid = v_q[DEPTH-1];
    assign busy      = |v_q;
    assign out_sum   = g_stage[DEPTH-1].data_q[W-1:0];
    assign out_carry = g_stage[DEPTH-1].data_q[2*W-1:W];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Scoreboard bench for csa_tree_pipe: main 92x184 instance plus four parameter variants.
module tb_csa_tree_pipe;

    localparam int unsigned N     = 92;
    localparam int unsigned W     = 184;
    localparam int unsigned DEPTH = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_valid, out_ready;
    logic [N*W-1:0] in_ops;
    logic           in_ready, out_valid, busy;
    logic [W-1:0]   out_sum, out_carry;

    csa_tree_pipe #(.N_OPS(N), .W(W), .LAYERS_PER_STAGE(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .busy(busy));

    logic           sw_valid, sw_ready;
    logic [23:0]    s0_ops;
    logic [31:0]    s1_ops;
    logic [N*W-1:0] s2_ops, s3_ops;
    logic           s0_ir, s0_ov, s0_bz, s1_ir, s1_ov, s1_bz;
    logic           s2_ir, s2_ov, s2_bz, s3_ir, s3_ov, s3_bz;
    logic [7:0]     s0_s, s0_c, s1_s, s1_c;
    logic [W-1:0]   s2_s, s2_c, s3_s, s3_c;

    csa_tree_pipe #(.N_OPS(3), .W(8), .LAYERS_PER_STAGE(1)) sw0 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s0_ir),
        .in_ops(s0_ops), .out_valid(s0_ov), .out_ready(sw_ready),
        .out_sum(s0_s), .out_carry(s0_c), .busy(s0_bz));
    csa_tree_pipe #(.N_OPS(4), .W(8), .LAYERS_PER_STAGE(1)) sw1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_ir),
        .in_ops(s1_ops), .out_valid(s1_ov), .out_ready(sw_ready),
        .out_sum(s1_s), .out_carry(s1_c), .busy(s1_bz));
    csa_tree_pipe #(.N_OPS(N), .W(W), .LAYERS_PER_STAGE(10)) sw2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s2_ir),
        .in_ops(s2_ops), .out_valid(s2_ov), .out_ready(sw_ready),
        .out_sum(s2_s), .out_carry(s2_c), .busy(s2_bz));
    csa_tree_pipe #(.N_OPS(N), .W(W), .LAYERS_PER_STAGE(3)) sw3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s3_ir),
        .in_ops(s3_ops), .out_valid(s3_ov), .out_ready(sw_ready),
        .out_sum(s3_s), .out_carry(s3_c), .busy(s3_bz));

    typedef struct {
        logic [W-1:0] s;
        int           c;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           nvalid = 0;
    int           nstall = 0;
    bit           lat_chk = 1'b0;
    bit           acc = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] snap_s, snap_c;
    int           s_lat[4];
    logic [W-1:0] s_got[4];
    logic [W-1:0] s_exp[4];
    int           s_dep[4];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [N*W-1:0] make_ops(input int mode);
        logic [N*W-1:0] o;
        logic [191:0]   r;
        for (int k = 0; k < int'(N); k++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            case (mode)
                0:       o[k*W +: W] = W'(1);
                1:       o[k*W +: W] = '1;
                default: o[k*W +: W] = r[W-1:0];
            endcase
        end
        return o;
    endfunction

    // Reference model: plain modular sum of every operand.
    function automatic logic [W-1:0] sum_ops(input logic [N*W-1:0] o);
        logic [W-1:0] a;
        a = '0;
        for (int k = 0; k < int'(N); k++) a = a + o[k*W +: W];
        return a;
    endfunction

    // One clock: check outputs and record handshakes mid-cycle, then advance.
    task automatic tick();
        logic [W-1:0] sm;
        exp_t         e;
        @(negedge clk);
        sm = out_sum + out_carry;
        if (out_valid) begin
            nvalid++;
            chk("unexpected_output", 256'(q.size() != 0), 256'(1));
            if (q.size() != 0) begin
                chk("sum", 256'(sm), 256'(q[0].s));
                if (out_ready) begin
                    if (lat_chk) chk("latency", 256'(cyc - q[0].c), 256'(DEPTH));
                    void'(q.pop_front());
                end
            end
        end
        if (out_valid && !out_ready) begin
            nstall++;
            chk("stall_in_ready", 256'(in_ready), 256'(0));
            if (prev_stall) begin
                chk("hold_sum", 256'(out_sum), 256'(snap_s));
                chk("hold_carry", 256'(out_carry), 256'(snap_c));
            end
            snap_s = out_sum;
            snap_c = out_carry;
            prev_stall = 1'b1;
        end else begin
            prev_stall = 1'b0;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e.s = sum_ops(in_ops);
            e.c = cyc;
            q.push_back(e);
        end
        if (s0_ov && s_lat[0] < 0) begin s_lat[0] = cyc; s_got[0] = W'(8'(s0_s + s0_c)); end
        if (s1_ov && s_lat[1] < 0) begin s_lat[1] = cyc; s_got[1] = W'(8'(s1_s + s1_c)); end
        if (s2_ov && s_lat[2] < 0) begin s_lat[2] = cyc; s_got[2] = s2_s + s2_c; end
        if (s3_ov && s_lat[3] < 0) begin s_lat[3] = cyc; s_got[3] = s3_s + s3_c; end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Source holds each set until accepted; out_ready low inside the stall window.
    task automatic send(input int n, input int mode, input int stall_from, input int stall_len);
        int sent;
        int k;
        sent = 0;
        k = 0;
        in_ops = make_ops(mode);
        in_valid = 1'b1;
        while (sent < n && k < 200) begin
            out_ready = !(k >= stall_from && k < stall_from + stall_len);
            tick();
            if (acc) begin
                sent++;
                in_ops = make_ops(mode);
            end
            k++;
        end
        in_valid = 1'b0;
        chk("sets_sent", 256'(sent), 256'(n));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 60 && q.size() != 0; k++) tick();
        repeat (3) tick();
        chk("drain_empty", 256'(q.size()), 256'(0));
    endtask

    initial begin
        logic [7:0] e8;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_ops = '0;
        sw_valid = 1'b0;
        sw_ready = 1'b1;
        s0_ops = '0;
        s1_ops = '0;
        s2_ops = '0;
        s3_ops = '0;
        s_dep = '{1, 2, 1, 4};
        for (int j = 0; j < 4; j++) s_lat[j] = -1;

        #12;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_sum", 256'(out_sum), 256'(0));
        chk("rst_out_carry", 256'(out_carry), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", 256'(out_valid), 256'(0));
        chk("post_rst_in_ready", 256'(in_ready), 256'(1));

        // All ones: single pulse, sum 92, pipe empties.
        lat_chk = 1'b1;
        nvalid = 0;
        send(1, 0, 1000, 0);
        repeat (10) tick();
        chk("ones_pulses", 256'(nvalid), 256'(1));
        chk("ones_busy", 256'(busy), 256'(0));
        chk("ones_drained", 256'(q.size()), 256'(0));

        // All ones-complement operands.
        nvalid = 0;
        send(1, 1, 1000, 0);
        repeat (10) tick();
        chk("max_pulses", 256'(nvalid), 256'(1));

        // Back-to-back random sets at full throughput.
        nvalid = 0;
        send(20, 2, 1000, 0);
        drain();
        chk("b2b_results", 256'(nvalid), 256'(20));

        // Backpressure window of 7 cycles while output is valid.
        lat_chk = 1'b0;
        nstall = 0;
        send(12, 2, 6, 7);
        drain();
        chk("bp_stall_cycles", 256'(nstall), 256'(7));

        // Reset with the pipe full and stalled discards everything.
        send(5, 2, 0, 1000);
        chk("pre_rst_valid", 256'(out_valid), 256'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_out_sum", 256'(out_sum), 256'(0));
        chk("mid_rst_out_carry", 256'(out_carry), 256'(0));
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
        q.delete();
        prev_stall = 1'b0;
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        nvalid = 0;
        repeat (12) tick();
        chk("rst_discard", 256'(nvalid), 256'(0));

        // Parameter variants: one set each, latency equals their depth.
        s0_ops = $urandom();
        s1_ops = $urandom();
        s2_ops = make_ops(2);
        s3_ops = make_ops(2);
        e8 = s0_ops[7:0] + s0_ops[15:8] + s0_ops[23:16];
        s_exp[0] = W'(e8);
        e8 = s1_ops[7:0] + s1_ops[15:8] + s1_ops[23:16] + s1_ops[31:24];
        s_exp[1] = W'(e8);
        s_exp[2] = sum_ops(s2_ops);
        s_exp[3] = sum_ops(s3_ops);
        sw_valid = 1'b1;
        begin
            int c0;
            c0 = cyc;
            tick();
            sw_valid = 1'b0;
            repeat (8) tick();
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("sweep%0d_latency", j), 256'(s_lat[j] - c0), 256'(s_dep[j]));
                chk($sformatf("sweep%0d_sum", j), 256'(s_got[j]), 256'(s_exp[j]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
